data_memory_responder: RTL
==========================

// Module: data_memory_responder
// PURPOSE
//  Responder side of the pipeline's data-memory interface: accepts memRead/memWrite
//  requests issued by the MEM stage, models a word-addressed data RAM with fixed
//  multi-cycle access latency, and drives memStall back to the hazard/control logic
//  to freeze the pipeline while an access is in flight. Sits between EX/MEM and MEM/WB.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words in the array (power of two)
//  ADDR_W       8    log2(DEPTH_WORDS); word index = address[ADDR_W+1:2]
//  LATENCY      2    access latency in cycles, legal range 1..15
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   synchronous, active-high reset
//  memRead    in   1   read request from MEM stage, held stable while memStall=1
//  memWrite   in   1   write request from MEM stage, held stable while memStall=1
//  address    in   32  byte address
//  writeData  in   32  store data
//  readData   out  32  load data, valid only in the memDone cycle
//  memStall   out  1   pipeline freeze request
//  memDone    out  1   one-cycle pulse: access complete
//  memError   out  1   one-cycle pulse with memDone: access rejected
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, readData=0, memDone=0, memError=0, array cleared to 0.
//  FSM states IDLE, BUSY, DONE.
//  - IDLE: request (memRead|memWrite) seen in cycle T -> capture address, writeData,
//    op; counter=LATENCY-1; go BUSY if LATENCY>1 else DONE. memStall=1 in cycle T
//    (combinational from request in IDLE).
//  - BUSY: memStall=1; counter decrements each cycle; at counter==1 go DONE.
//  - DONE (cycle T+LATENCY): memStall=0, memDone=1, readData=array[idx] for reads
//    (0 for writes); write committed to array on the edge entering DONE. Always
//    returns to IDLE; request lines still high in DONE are ignored (same instruction).
//  - Total stall = LATENCY cycles per access; back-to-back requests restart from IDLE
//    on the cycle after DONE; no request lost.
//  Errors (memError=1 in DONE, no array write, readData=0):
//   address[1:0]!=0 (misaligned); memRead&memWrite both high.
//  Address wrap: bits above ADDR_W+1 ignored; index wraps modulo DEPTH_WORDS.
//  Inputs changing during BUSY are ignored; captured copies used throughout.
//  rst asserted mid-access: return to IDLE next edge, pending write discarded,
//  no memDone pulse, memStall deasserted next cycle.
// CONFIGURATION
//  DMEM_POSTED_WRITE_EN defined: writes take zero stall - in IDLE a valid, aligned
//   memWrite commits on the same edge, memStall=0, memDone=0, FSM stays IDLE;
//   reads and error cases unchanged (error write still enters BUSY/DONE path).
//  Undefined: writes follow full LATENCY handshake as above.
// TESTING
//  1 rst, read addr 0x10 -> readData=0 at T+LATENCY, memStall high exactly 2 cycles.
//  2 write 0xDEADBEEF @0x40, then read @0x40 -> memDone pulses twice, read returns
//    0xDEADBEEF; @0x40+4*DEPTH_WORDS also returns 0xDEADBEEF (wrap).
//  3 read @0x41 -> memError=1, memDone=1, readData=0; write @0x42 leaves word unchanged.
//  4 memRead=memWrite=1 @0x80 -> memError pulse, word 0x80 unchanged.
//  5 write 0x1234 @0x20, rst in first BUSY cycle -> memStall low after, no memDone,
//    read @0x20 returns 0.
//  6 DMEM_POSTED_WRITE_EN: write 0x55 @0x8 -> memStall never high; next-cycle read 0x55.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Data-memory request/response bundle between the MEM stage and the data RAM responder.
//   master : MEM stage side  -> drives memRead, memWrite, address, writeData
//   slave  : responder side  -> drives readData, memStall, memDone, memError
interface data_memory_responder_if;
   logic        memRead;
   logic        memWrite;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        memStall;
   logic        memDone;
   logic        memError;

   modport master (
      output memRead, memWrite, address, writeData,
      input  readData, memStall, memDone, memError
   );

   modport slave (
      input  memRead, memWrite, address, writeData,
      output readData, memStall, memDone, memError
   );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: word-addressed RAM with fixed multi-cycle access latency.
// It freezes the pipeline through memStall while an access is in flight and reports
// completion with a one-cycle memDone pulse (memError alongside for rejected accesses).
// Ports:
//   clk  - clock, all state updates on rising edge
//   rst  - synchronous active-high reset
//   bus  - data_memory_responder_if.slave (request in, readData/memStall/memDone/memError out)
// Parameters: DEPTH_WORDS (power of two), ADDR_W = log2(DEPTH_WORDS), LATENCY (1..15).
// Build option: define DMEM_POSTED_WRITE_EN to make valid aligned writes commit in IDLE
// with zero stall and no memDone pulse.
//
// state | meaning
// IDLE  | waiting for a request; stall driven combinationally from the request
// BUSY  | access in flight, counter running down
// DONE  | one-cycle completion: memDone (and memError / readData) presented
module data_memory_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = 8,
   parameter int LATENCY     = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   data_memory_responder_if.slave    bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} stateT;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   stateT             state, nextState;
   logic [3:0]        counter;
   logic [ADDR_W-1:0] capIdx;
   logic [31:0]       capData;
   logic              capRead;
   logic              capWrite;
   logic              capErr;
   logic [31:0]       mem [DEPTH_WORDS];

   logic              request;
   logic              reqErr;
   logic              postedWrite;
   logic              startAccess;
   logic              commitNow;
   logic [ADDR_W-1:0] commitIdx;
   logic [31:0]       commitData;
   logic              unusedAddrBits;

   assign unusedAddrBits = ^bus.address[31:ADDR_W+2];

   assign request = bus.memRead | bus.memWrite;
   assign reqErr  = (bus.address[1:0] != 2'b00) | (bus.memRead & bus.memWrite);

`ifdef DMEM_POSTED_WRITE_EN
   assign postedWrite = (state == IDLE) & bus.memWrite & ~reqErr;
`else
   assign postedWrite = 1'b0;
`endif

   assign startAccess = (state == IDLE) & request & ~postedWrite;

   // Writes land on the edge that enters DONE; with LATENCY==1 that edge is the
   // capture edge itself, so the live inputs are used instead of the captured copies.
   always_comb begin
      commitNow  = 1'b0;
      commitIdx  = capIdx;
      commitData = capData;
      if (state == IDLE) begin
         commitIdx  = bus.address[ADDR_W+1:2];
         commitData = bus.writeData;
         commitNow  = postedWrite |
                      (startAccess & (LATENCY == 1) & bus.memWrite & ~reqErr);
      end else if (state == BUSY) begin
         commitNow  = (counter == 4'd1) & capWrite & ~capErr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         counter  <= 4'd0;
         capIdx   <= '0;
         capData  <= 32'd0;
         capRead  <= 1'b0;
         capWrite <= 1'b0;
         capErr   <= 1'b0;
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
      end else begin
         state <= nextState;
         if (startAccess) begin
            capIdx   <= bus.address[ADDR_W+1:2];
            capData  <= bus.writeData;
            capRead  <= bus.memRead;
            capWrite <= bus.memWrite;
            capErr   <= reqErr;
            counter  <= LAT_M1;
         end else if (state == BUSY) begin
            counter <= counter - 4'd1;
         end
         if (commitNow) mem[commitIdx] <= commitData;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (startAccess) nextState = (LATENCY > 1) ? BUSY : DONE;
         BUSY: if (counter == 4'd1) nextState = DONE;
         DONE: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      bus.memStall = startAccess | (state == BUSY);
      bus.memDone  = (state == DONE);
      bus.memError = (state == DONE) & capErr;
      bus.readData = 32'd0;
      if ((state == DONE) && capRead && !capErr) bus.readData = mem[capIdx];
   end
endmodule
